// File: rtl/integrate_dump_accumulator_if.sv
// Stream bundle for the integrate-and-dump accumulator: sample input side and block-sum output side.
// Signal names are from the accumulator's point of view (i_* flows into it, o_* out of it).
interface integrate_dump_accumulator_if #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_ACC = 24
);
    logic                 i_clear;
    logic                 i_valid;
    logic                 o_ready;
    logic [WIDTH_IN-1:0]  i_data;
    logic                 o_valid;
    logic                 i_ready;
    logic [WIDTH_ACC-1:0] o_data;
    logic                 o_ovf;

    // Producer/consumer side, driving samples and draining block sums.
    modport master (
        output i_clear, i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_ovf
    );

    // Accumulator side.
    modport slave (
        input  i_clear, i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_ovf
    );
endinterface

// File: rtl/integrate_dump_accumulator.sv
// Extends narrow samples, sums DUMP_LEN of them into a wide (optionally saturating)
// accumulator and emits one registered word per block.
module integrate_dump_accumulator #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_ACC = 24,
    parameter int DUMP_LEN  = 8,
    parameter bit IS_SIGNED = 1'b1
) (
    input logic i_clk,
    input logic i_rst,
    integrate_dump_accumulator_if.slave io_bus
);
    localparam int CNT_W = (DUMP_LEN > 1) ? $clog2(DUMP_LEN) : 1;
    localparam int EXT_W = WIDTH_ACC + 1 - WIDTH_IN;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DUMP_LEN - 1);

    if (WIDTH_ACC < WIDTH_IN) begin : g_bad_width
        $error("integrate_dump_accumulator: WIDTH_ACC must be >= WIDTH_IN");
    end
    if (DUMP_LEN < 1) begin : g_bad_len
        $error("integrate_dump_accumulator: DUMP_LEN must be >= 1");
    end

    logic [WIDTH_ACC-1:0] r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_blk_ovf;
    logic                 r_valid;
    logic [WIDTH_ACC-1:0] r_data;
    logic                 r_ovf;

    logic                 w_sign_in;
    logic                 w_sign_acc;
    logic [WIDTH_ACC:0]   w_x;
    logic [WIDTH_ACC:0]   w_acc_ext;
    logic [WIDTH_ACC:0]   w_s;
    logic                 w_ovf;
    logic [WIDTH_ACC-1:0] w_clamp;
    logic [WIDTH_ACC-1:0] w_sum;
    logic                 w_last;
    logic                 w_ready;
    logic                 w_in_beat;
    logic                 w_out_beat;

    assign w_sign_in  = IS_SIGNED ? io_bus.i_data[WIDTH_IN-1] : 1'b0;
    assign w_sign_acc = IS_SIGNED ? r_acc[WIDTH_ACC-1] : 1'b0;
    assign w_x        = {{EXT_W{w_sign_in}}, io_bus.i_data};
    assign w_acc_ext  = {w_sign_acc, r_acc};
    assign w_s        = w_acc_ext + w_x;

    // One guard bit is enough: a single add can only step one range past the limit.
    assign w_ovf   = IS_SIGNED ? (w_s[WIDTH_ACC] ^ w_s[WIDTH_ACC-1]) : w_s[WIDTH_ACC];
    assign w_clamp = !IS_SIGNED ? {WIDTH_ACC{1'b1}} :
                     (w_s[WIDTH_ACC] ? {1'b1, {(WIDTH_ACC-1){1'b0}}}
                                     : {1'b0, {(WIDTH_ACC-1){1'b1}}});
    assign w_sum   = w_ovf ? w_clamp : w_s[WIDTH_ACC-1:0];

    // Valid/ready: a beat happens on a side when its valid and ready are both high in the
    // same cycle; valid never waits for ready. Only the final beat of a block can stall,
    // and only while the previous word is still unconsumed.
    assign w_last     = (r_cnt == LAST_CNT);
    assign w_ready    = !(w_last && r_valid && !io_bus.i_ready);
    assign w_in_beat  = io_bus.i_valid && w_ready;
    assign w_out_beat = r_valid && io_bus.i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_blk_ovf <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_out_beat) begin
                r_valid <= 1'b0;
            end
            // Clear wins over a same-cycle sample but leaves a pending word alone.
            if (io_bus.i_clear) begin
                r_acc     <= '0;
                r_cnt     <= '0;
                r_blk_ovf <= 1'b0;
            end else if (w_in_beat) begin
                if (w_last) begin
                    r_data    <= w_sum;
                    r_ovf     <= r_blk_ovf | w_ovf;
                    r_valid   <= 1'b1;
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    r_blk_ovf <= 1'b0;
                end else begin
                    r_acc     <= w_sum;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    r_blk_ovf <= r_blk_ovf | w_ovf;
                end
            end
        end
    end

    assign io_bus.o_ready = w_ready;
    assign io_bus.o_valid = r_valid;
    assign io_bus.o_data  = r_data;
    assign io_bus.o_ovf   = r_ovf;
endmodule

// File: tb/tb_integrate_dump_accumulator.sv
// Directed scoreboard bench for integrate_dump_accumulator over four parameter sets.
module tb_integrate_dump_accumulator;
  logic clk;
  logic rst;

  // a: 16/24 signed len 4, b: defaults, c: 16/17 signed len 8, d: 16/18 unsigned len 4
  integrate_dump_accumulator_if #(.WIDTH_IN(16), .WIDTH_ACC(24)) a_if ();
  integrate_dump_accumulator_if #(.WIDTH_IN(16), .WIDTH_ACC(24)) b_if ();
  integrate_dump_accumulator_if #(.WIDTH_IN(16), .WIDTH_ACC(17)) c_if ();
  integrate_dump_accumulator_if #(.WIDTH_IN(16), .WIDTH_ACC(18)) d_if ();

  integrate_dump_accumulator #(.WIDTH_IN(16), .WIDTH_ACC(24), .DUMP_LEN(4), .IS_SIGNED(1'b1))
    dut_a (.i_clk(clk), .i_rst(rst), .io_bus(a_if));
  integrate_dump_accumulator #(.WIDTH_IN(16), .WIDTH_ACC(24), .DUMP_LEN(8), .IS_SIGNED(1'b1))
    dut_b (.i_clk(clk), .i_rst(rst), .io_bus(b_if));
  integrate_dump_accumulator #(.WIDTH_IN(16), .WIDTH_ACC(17), .DUMP_LEN(8), .IS_SIGNED(1'b1))
    dut_c (.i_clk(clk), .i_rst(rst), .io_bus(c_if));
  integrate_dump_accumulator #(.WIDTH_IN(16), .WIDTH_ACC(18), .DUMP_LEN(4), .IS_SIGNED(1'b0))
    dut_d (.i_clk(clk), .i_rst(rst), .io_bus(d_if));

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- scoreboard: {ovf, data zero-extended to 24 bits} ----
  logic [24:0] exp_a_q[$];
  logic [24:0] exp_b_q[$];
  logic [24:0] exp_c_q[$];
  logic [24:0] exp_d_q[$];
  int check_cnt = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
  endtask

  // ---- monitors ----
  always @(negedge clk) begin
    if (!rst && a_if.o_valid && a_if.i_ready) begin
      if (exp_a_q.size() == 0) check("a_unexpected_word", 32'({a_if.o_ovf, a_if.o_data}), 32'h0);
      else check("a_word", 32'({a_if.o_ovf, a_if.o_data}), 32'(exp_a_q.pop_front()));
    end
  end
  always @(negedge clk) begin
    if (!rst && b_if.o_valid && b_if.i_ready) begin
      if (exp_b_q.size() == 0) check("b_unexpected_word", 32'({b_if.o_ovf, b_if.o_data}), 32'h0);
      else check("b_word", 32'({b_if.o_ovf, b_if.o_data}), 32'(exp_b_q.pop_front()));
    end
  end
  always @(negedge clk) begin
    if (!rst && c_if.o_valid && c_if.i_ready) begin
      if (exp_c_q.size() == 0) check("c_unexpected_word", 32'({c_if.o_ovf, 7'd0, c_if.o_data}), 32'h0);
      else check("c_word", 32'({c_if.o_ovf, 7'd0, c_if.o_data}), 32'(exp_c_q.pop_front()));
    end
  end
  always @(negedge clk) begin
    if (!rst && d_if.o_valid && d_if.i_ready) begin
      if (exp_d_q.size() == 0) check("d_unexpected_word", 32'({d_if.o_ovf, 6'd0, d_if.o_data}), 32'h0);
      else check("d_word", 32'({d_if.o_ovf, 6'd0, d_if.o_data}), 32'(exp_d_q.pop_front()));
    end
  end

  // ---- driver tasks ----
  task automatic set_in(input int inst, input logic v, input logic [15:0] d);
    case (inst)
      0: begin a_if.i_valid = v; a_if.i_data = d; end
      1: begin b_if.i_valid = v; b_if.i_data = d; end
      2: begin c_if.i_valid = v; c_if.i_data = d; end
      default: begin d_if.i_valid = v; d_if.i_data = d; end
    endcase
  endtask

  function automatic logic ready_of(input int inst);
    case (inst)
      0: return a_if.o_ready;
      1: return b_if.o_ready;
      2: return c_if.o_ready;
      default: return d_if.o_ready;
    endcase
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the sample.
  task automatic beat(input int inst, input logic [15:0] d);
    logic got;
    got = 1'b0;
    set_in(inst, 1'b1, d);
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      got = ready_of(inst);
      @(posedge clk);
      #1;
    end
    set_in(inst, 1'b0, 16'h0);
    if (!got) check("beat_timeout", 32'(inst), 32'hFFFF_FFFF);
  endtask

  task automatic beats(input int inst, input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) beat(inst, d);
  endtask

  // ---- stimulus ----
  initial begin
    rst = 1'b1;
    a_if.i_clear = 1'b0; a_if.i_valid = 1'b0; a_if.i_data = '0; a_if.i_ready = 1'b1;
    b_if.i_clear = 1'b0; b_if.i_valid = 1'b0; b_if.i_data = '0; b_if.i_ready = 1'b1;
    c_if.i_clear = 1'b0; c_if.i_valid = 1'b0; c_if.i_data = '0; c_if.i_ready = 1'b1;
    d_if.i_clear = 1'b0; d_if.i_valid = 1'b0; d_if.i_data = '0; d_if.i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset_o_valid", 32'(a_if.o_valid), 32'd0);
    check("reset_o_data", 32'(a_if.o_data), 32'd0);
    check("reset_o_ovf", 32'(a_if.o_ovf), 32'd0);
    check("reset_o_ready", 32'(a_if.o_ready), 32'd1);
    @(posedge clk); #1;

    // Simple block 1+2+3+4 with latency check.
    exp_a_q.push_back({1'b0, 24'd10});
    beat(0, 16'd1); beat(0, 16'd2); beat(0, 16'd3);
    check("t1_no_valid_early", 32'(a_if.o_valid), 32'd0);
    beat(0, 16'd4);
    @(negedge clk);
    check("t1_valid_after_final", 32'(a_if.o_valid), 32'd1);
    @(posedge clk); #1;
    repeat (2) @(posedge clk); #1;

    // Stall: A waits, B accumulates 3 beats, 4th beat blocked until A drains.
    a_if.i_ready = 1'b0;
    exp_a_q.push_back({1'b0, 24'd4});
    beats(0, 16'd1, 4);
    exp_a_q.push_back({1'b0, 24'd8});
    beats(0, 16'd2, 3);
    set_in(0, 1'b1, 16'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_ready_low", 32'(a_if.o_ready), 32'd0);
      check("t4_data_held", 32'(a_if.o_data), 32'd4);
    end
    @(posedge clk); #1;
    a_if.i_ready = 1'b1;
    @(negedge clk);
    check("t4_ready_back", 32'(a_if.o_ready), 32'd1);
    @(posedge clk); #1;
    set_in(0, 1'b0, 16'h0);
    @(negedge clk);
    check("t4_b_valid", 32'(a_if.o_valid), 32'd1);
    check("t4_b_data", 32'(a_if.o_data), 32'd8);
    @(posedge clk); #1;
    repeat (2) @(posedge clk); #1;

    // Clear drops the partial sum and the same-cycle sample.
    exp_a_q.push_back({1'b0, 24'd4});
    beat(0, 16'd5); beat(0, 16'd5);
    a_if.i_clear = 1'b1;
    set_in(0, 1'b1, 16'd7);
    @(posedge clk); #1;
    a_if.i_clear = 1'b0;
    set_in(0, 1'b0, 16'h0);
    beats(0, 16'd1, 4);
    repeat (3) @(posedge clk); #1;

    // Most negative samples on defaults.
    exp_b_q.push_back({1'b0, 24'hFC0000});
    beats(1, 16'h8000, 8);
    repeat (3) @(posedge clk); #1;

    // Saturation on a 17-bit accumulator, both directions, and sticky flag clears per block.
    exp_c_q.push_back({1'b1, 24'h00FFFF});
    beats(2, 16'h7FFF, 8);
    exp_c_q.push_back({1'b0, 24'd8});
    beats(2, 16'd1, 8);
    exp_c_q.push_back({1'b1, 24'h010000});
    beats(2, 16'h8000, 8);
    repeat (3) @(posedge clk); #1;

    // Unsigned growth, then reset mid-block.
    exp_d_q.push_back({1'b0, 24'h03FFFC});
    beats(3, 16'hFFFF, 4);
    beats(3, 16'h1234, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_o_valid", 32'(d_if.o_valid), 32'd0);
    check("t6_rst_o_data", 32'(d_if.o_data), 32'd0);
    check("t6_rst_o_ovf", 32'(d_if.o_ovf), 32'd0);
    @(posedge clk); #1;
    exp_d_q.push_back({1'b0, 24'd4});
    beats(3, 16'd1, 4);
    repeat (4) @(posedge clk); #1;

    check("a_queue_empty", 32'(exp_a_q.size()), 32'd0);
    check("b_queue_empty", 32'(exp_b_q.size()), 32'd0);
    check("c_queue_empty", 32'(exp_c_q.size()), 32'd0);
    check("d_queue_empty", 32'(exp_d_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
